x2050bs: RTL and testbench
==========================

# x2050bs

Byte serializer for the 2050 data flow: accepts a full storage word with a starting byte count, direction and byte total, then emits one byte per handshake, stepping its internal byte counter up or down modulo the word width, the way the ROS UP field does. It reads out what the byte counter selects and sits between the word-wide local-storage/SDR path and byte-wide consumers (mover, channel, decimal adder feed).

## Interface
- W, 2, byte-counter width; word holds N = 2**W bytes (default 4, 32-bit word)
- i_clk  input  1  clock, all logic on rising edge
- i_reset  input  1  synchronous, active-low reset
- i_ld_valid  input  1  load request
- o_ld_ready  output  1  block idle and able to accept a load
- i_ld_word  input  8*N  word to serialize; byte 0 = bits [8N-1:8N-8] (big-endian)
- i_ld_bc  input  W  starting byte number
- i_ld_up  input  1  1 = increment bc per byte, 0 = decrement
- i_ld_cnt  input  W  number of bytes to send minus one
- i_abort  input  1  drop the current transfer
- o_b_valid  output  1  byte available
- i_b_ready  input  1  consumer accepts byte
- o_byte  output  8  current byte, i.e. word byte o_bc
- o_bc  output  W  current byte counter
- o_last  output  1  current byte is the final one of the transfer
- o_busy  output  1  transfer in progress

## Operation
- States: IDLE, SEND.
- IDLE: o_ld_ready=1, o_b_valid=0. i_ld_valid=1 loads word, bc, direction, remaining=i_ld_cnt, and goes to SEND.
- SEND: o_ld_ready=0, o_b_valid=1, o_byte = word byte o_bc, o_last = (remaining==0).
- Byte accept (o_b_valid & i_b_ready): if o_last, go to IDLE and hold o_bc. Otherwise bc <= bc+1 (up) or bc-1 (down), both mod N, and remaining <= remaining-1.
- Wrap-around: bc N-1 going up becomes 0; bc 0 going down becomes N-1. i_ld_cnt=N-1 sends every byte exactly once.
- Stall: with i_b_ready=0, o_byte, o_bc and o_last hold steady.
- i_abort in SEND: go to IDLE next cycle, no byte is consumed, and o_bc holds. i_abort wins over a simultaneous accept. It is ignored in IDLE and does not block a same-cycle load.
- i_ld_valid during SEND is ignored. The load is not queued.
- Reset (i_reset=0), including mid-transfer: state IDLE, o_bc=0, remaining=0, word=0, o_b_valid=0, o_last=0, o_busy=0, o_ld_ready=1 on the following cycle.

## Timing
- Load accepted at edge t; first byte is valid from t+1 (latency 1).
- Sustained throughput is one byte per cycle with i_b_ready held high.
- After the last accept, o_ld_ready=1 the next cycle, so there is one idle bubble between transfers.
- o_byte, o_bc, o_last and o_b_valid are registered or derived only from registered state, with no combinational path from i_b_ready or i_ld_*.
- o_busy equals (state==SEND).

## Configuration
- X2050BS_PARITY_EN defined: adds output o_bpar (1 bit), the odd parity of o_byte, matching 2050 storage byte parity. It is combinational from the registered byte and valid whenever o_b_valid=1.
- Undefined: the o_bpar port and logic are absent. All other behaviour is identical.

## Test plan
- Load word 0x11223344, bc=0, up, cnt=3, ready always high -> bytes 11,22,33,44 on cycles t+1..t+4 with o_bc 0,1,2,3; o_last only on 44; o_ld_ready=1 at t+5.
- Load 0xA0B0C0D0, bc=1, down, cnt=3 -> bytes B0,A0,D0,C0 with o_bc 1,0,3,2 (wrap 0→3).
- Load 0x01020304, bc=2, up, cnt=1, i_b_ready low for 3 cycles -> o_byte stays 03 with o_bc=2 throughout the stall, then 03 followed by 04 (last); o_bc ends at 3.
- Start a 4-byte transfer, assert i_abort together with i_b_ready on the 2nd byte -> IDLE next cycle, o_bc=1, second byte not consumed; a new load in that cycle is ignored.
- Assert i_reset=0 during byte 3 of a transfer -> next cycle o_bc=0, o_b_valid=0, o_ld_ready=1; a new load after release streams normally.
- With X2050BS_PARITY_EN: bytes 00, 01 and FF -> o_bpar 1, 0 and 1.

Source files
------------

// File: rtl/x2050bs.sv
// x2050bs: byte serializer stepping a byte counter up/down mod N over a loaded word.
// Optional odd byte parity output o_bpar when X2050BS_PARITY_EN is defined.
module x2050bs #(
  parameter int W = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_ld_valid,
  output logic               o_ld_ready,
  input  logic [8*(2**W)-1:0] i_ld_word,
  input  logic [W-1:0]       i_ld_bc,
  input  logic               i_ld_up,
  input  logic [W-1:0]       i_ld_cnt,
  input  logic               i_abort,
  output logic               o_b_valid,
  input  logic               i_b_ready,
  output logic [7:0]         o_byte,
  output logic [W-1:0]       o_bc,
  output logic               o_last,
`ifdef X2050BS_PARITY_EN
  output logic               o_bpar,
`endif
  output logic               o_busy
);
  localparam int N = 2**W;

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q;
  logic [8*N-1:0]   word_q;
  logic [W-1:0]     bc_q, bc_d, rem_q;
  logic             up_q;
  logic [7:0]       byte_sel;

  // Counter width is exactly W bits, so +/-1 wraps modulo N for free.
  assign bc_d = up_q ? bc_q + W'(1) : bc_q - W'(1);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      bc_q    <= '0;
      rem_q   <= '0;
      up_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (i_ld_valid) begin
          word_q  <= i_ld_word;
          bc_q    <= i_ld_bc;
          up_q    <= i_ld_up;
          rem_q   <= i_ld_cnt;
          state_q <= SEND;
        end
        SEND: begin
          // Abort beats a simultaneous accept; bc is left where it was.
          if (i_abort) begin
            state_q <= IDLE;
          end else if (i_b_ready) begin
            if (rem_q == '0) begin
              state_q <= IDLE;
            end else begin
              bc_q  <= bc_d;
              rem_q <= rem_q - W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Byte 0 is the most significant byte of the word.
  always_comb begin
    byte_sel = '0;
    for (int k = 0; k < N; k++)
      if (bc_q == W'(k)) byte_sel = word_q[8*(N-1-k) +: 8];
  end

  assign o_ld_ready = (state_q == IDLE);
  assign o_b_valid  = (state_q == SEND);
  assign o_busy     = (state_q == SEND);
  assign o_last     = (state_q == SEND) && (rem_q == '0);
  assign o_byte     = byte_sel;
  assign o_bc       = bc_q;

`ifdef X2050BS_PARITY_EN
  assign o_bpar = ~^byte_sel;
`endif

endmodule

// File: tb/tb_x2050bs.sv
// Directed bench for x2050bs: queue-based transfer model checked every cycle plus literal pins.
module tb_x2050bs;
  localparam int W = 2;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ld_valid = 1'b0;
  logic           ld_ready;
  logic [8*N-1:0] ld_word = '0;
  logic [W-1:0]   ld_bc = '0;
  logic           ld_up = 1'b0;
  logic [W-1:0]   ld_cnt = '0;
  logic           abort = 1'b0;
  logic           b_valid;
  logic           b_ready = 1'b0;
  logic [7:0]     obyte;
  logic [W-1:0]   obc;
  logic           olast;
  logic           obusy;
`ifdef X2050BS_PARITY_EN
  logic           obpar;
`endif

  x2050bs #(.W(W)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_ld_valid(ld_valid), .o_ld_ready(ld_ready), .i_ld_word(ld_word),
    .i_ld_bc(ld_bc), .i_ld_up(ld_up), .i_ld_cnt(ld_cnt), .i_abort(abort),
    .o_b_valid(b_valid), .i_b_ready(b_ready), .o_byte(obyte), .o_bc(obc),
    .o_last(olast),
`ifdef X2050BS_PARITY_EN
    .o_bpar(obpar),
`endif
    .o_busy(obusy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: at load time expand the whole transfer into a list of (bc, byte) pairs.
  int m_bc_q[$];
  int m_by_q[$];
  bit m_busy = 1'b0;
  int m_idx = 0;
  int m_cnt = 0;
  int m_bc = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_bc = 0;
    end else if (!m_busy) begin
      if (ld_valid) begin
        m_bc_q.delete();
        m_by_q.delete();
        m_cnt = int'(ld_cnt);
        for (int k = 0; k <= m_cnt; k++) begin
          int b;
          b = ld_up ? (int'(ld_bc) + k) % N : (int'(ld_bc) + N - k) % N;
          m_bc_q.push_back(b);
          m_by_q.push_back(int'((ld_word >> (8*(N-1-b))) & 32'hFF));
        end
        m_busy = 1'b1;
        m_idx = 0;
        m_bc = m_bc_q[0];
      end
    end else if (abort) begin
      m_busy = 1'b0;
    end else if (b_ready) begin
      if (m_idx == m_cnt) m_busy = 1'b0;
      else begin
        m_idx++;
        m_bc = m_bc_q[m_idx];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ld_ready", 32'(ld_ready), 32'(!m_busy));
      chk("b_valid",  32'(b_valid),  32'(m_busy));
      chk("busy",     32'(obusy),    32'(m_busy));
      chk("bc",       32'(obc),      32'(m_bc));
      chk("last",     32'(olast),    32'(m_busy && m_idx == m_cnt));
      if (m_busy) begin
        chk("byte", 32'(obyte), 32'(m_by_q[m_idx]));
`ifdef X2050BS_PARITY_EN
        chk("bpar", 32'(obpar), 32'(($countones(m_by_q[m_idx]) % 2) == 0));
`endif
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [31:0] w, input int bc, input bit up, input int cnt);
    ld_word = w; ld_bc = W'(bc); ld_up = up; ld_cnt = W'(cnt); ld_valid = 1'b1;
    cyc();
    ld_valid = 1'b0;
  endtask

  task automatic pin(input string nm, input logic [7:0] by, input int bc, input bit last);
    chk({nm, ".byte"}, 32'(obyte), 32'(by));
    chk({nm, ".bc"},   32'(obc),   32'(bc));
    chk({nm, ".last"}, 32'(olast), 32'(last));
  endtask

  initial begin
    cyc(); cyc();
    chk("rst.ready", 32'(ld_ready), 32'd1);
    chk("rst.valid", 32'(b_valid), 32'd0);
    chk("rst.bc",    32'(obc), 32'd0);
    chk("rst.last",  32'(olast), 32'd0);
    chk("rst.busy",  32'(obusy), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    cyc();

    // Up, full word, ready always high.
    b_ready = 1'b1;
    load(32'h11223344, 0, 1'b1, 3);
    pin("t1.0", 8'h11, 0, 1'b0); cyc();
    pin("t1.1", 8'h22, 1, 1'b0); cyc();
    pin("t1.2", 8'h33, 2, 1'b0); cyc();
    pin("t1.3", 8'h44, 3, 1'b1); cyc();
    chk("t1.ready", 32'(ld_ready), 32'd1);

    // Down with wrap 0 -> 3.
    load(32'hA0B0C0D0, 1, 1'b0, 3);
    pin("t2.0", 8'hB0, 1, 1'b0); cyc();
    pin("t2.1", 8'hA0, 0, 1'b0); cyc();
    pin("t2.2", 8'hD0, 3, 1'b0); cyc();
    pin("t2.3", 8'hC0, 2, 1'b1); cyc();

    // Stall for three cycles.
    b_ready = 1'b0;
    load(32'h01020304, 2, 1'b1, 1);
    for (int s = 0; s < 3; s++) begin
      pin("t3.stall", 8'h03, 2, 1'b0); cyc();
    end
    b_ready = 1'b1;
    pin("t3.0", 8'h03, 2, 1'b0); cyc();
    pin("t3.1", 8'h04, 3, 1'b1); cyc();
    chk("t3.bc_hold", 32'(obc), 32'd3);

    // Abort with accept on 2nd byte; same-cycle load ignored.
    load(32'h55667788, 0, 1'b1, 3);
    cyc();
    pin("t4.1", 8'h66, 1, 1'b0);
    abort = 1'b1; ld_valid = 1'b1; ld_word = 32'hDEADBEEF; ld_bc = 2'd3;
    cyc();
    abort = 1'b0; ld_valid = 1'b0;
    chk("t4.ready", 32'(ld_ready), 32'd1);
    chk("t4.bc",    32'(obc), 32'd1);
    cyc();
    chk("t4.noq",   32'(b_valid), 32'd0);

    // Abort in IDLE does not block a load.
    abort = 1'b1;
    load(32'hCAFEF00D, 3, 1'b1, 0);
    abort = 1'b0;
    pin("t4b.0", 8'h0D, 3, 1'b1); cyc();

    // Reset mid-transfer during byte 3.
    load(32'h0A0B0C0D, 0, 1'b1, 3);
    cyc(); cyc();
    pin("t5.2", 8'h0C, 2, 1'b0);
    rst_n = 1'b0;
    cyc();
    chk("t5.bc",    32'(obc), 32'd0);
    chk("t5.valid", 32'(b_valid), 32'd0);
    chk("t5.ready", 32'(ld_ready), 32'd1);
    rst_n = 1'b1;
    cyc();
    load(32'h9192A3B4, 3, 1'b0, 2);
    pin("t5n.0", 8'hB4, 3, 1'b0); cyc();
    pin("t5n.1", 8'hA3, 2, 1'b0); cyc();
    pin("t5n.2", 8'h92, 1, 1'b1); cyc();

`ifdef X2050BS_PARITY_EN
    load(32'h0001FF00, 0, 1'b1, 2);
    chk("par.00", 32'(obpar), 32'd1); cyc();
    chk("par.01", 32'(obpar), 32'd0); cyc();
    chk("par.FF", 32'(obpar), 32'd1); cyc();
`endif

    // Short stretch of random back-to-back traffic with random ready.
    for (int r = 0; r < 40; r++) begin
      b_ready = 1'($urandom_range(0, 1));
      if (ld_ready) begin
        ld_word = $urandom; ld_bc = W'($urandom_range(0, 3));
        ld_up = 1'($urandom_range(0, 1)); ld_cnt = W'($urandom_range(0, 3));
        ld_valid = 1'b1;
      end else ld_valid = 1'b0;
      cyc();
    end
    ld_valid = 1'b0;
    b_ready = 1'b1;
    for (int r = 0; r < 6; r++) cyc();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
